// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between a client and the bit-serial ALU sequencer.
// The client drives the operands, op, start and ack. The sequencer drives
// ready, valid, result and carry_out.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             valid;
    logic             ack;

    modport master (
        output start, op, a, b, cin, ack,
        input  ready, result, carry_out, valid
    );

    modport slave (
        input  start, op, a, b, cin, ack,
        output ready, result, carry_out, valid
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a combinational single-bit ALU slice.
// Operands are shifted out LSB first. Each bit pair is held for SETTLE clocks
// before the slice result is sampled. The slice carry is chained back into
// slice_c, and the result bits are shifted into the result word from the top.
module alu_serial_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset,
    alu_serial_ctrl_if.slave    bus,
    output logic                slice_a,
    output logic                slice_b,
    output logic                slice_c,
    output logic                slice_s0,
    output logic                slice_s1,
    input  logic                slice_out,
    input  logic                slice_carry
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [1:0]       op_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [SW-1:0]    settle_cnt_r;

    // Slice inputs come straight from flops, so they only change on clock edges.
    assign slice_a  = a_sh_r[0];
    assign slice_b  = b_sh_r[0];
    assign slice_c  = carry_r;
    assign slice_s0 = op_r[0];
    assign slice_s1 = op_r[1];

    // Control FSM: accept, per-bit settle/sample sequencing, and the result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            a_sh_r        <= '0;
            b_sh_r        <= '0;
            carry_r       <= 1'b0;
            op_r          <= 2'b00;
            bit_cnt_r     <= '0;
            settle_cnt_r  <= '0;
            bus.ready     <= 1'b1;
            bus.valid     <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_r       <= bus.a;
                        b_sh_r       <= bus.b;
                        op_r         <= bus.op;
                        carry_r      <= bus.cin;
                        bit_cnt_r    <= '0;
                        settle_cnt_r <= SW'(SETTLE - 1);
                        bus.ready    <= 1'b0;
                        state_r      <= ST_RUN;
                    end else begin
                        bus.ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (settle_cnt_r != '0) begin
                        settle_cnt_r <= settle_cnt_r - SW'(1);
                    end else begin
                        // Sample edge: capture the slice result and present the next bit.
                        bus.result   <= {slice_out, bus.result[WIDTH-1:1]};
                        carry_r      <= slice_carry;
                        a_sh_r       <= {1'b0, a_sh_r[WIDTH-1:1]};
                        b_sh_r       <= {1'b0, b_sh_r[WIDTH-1:1]};
                        bit_cnt_r    <= bit_cnt_r + CW'(1);
                        settle_cnt_r <= SW'(SETTLE - 1);
                        if (bit_cnt_r == CW'(WIDTH - 1)) begin
                            bus.carry_out <= slice_carry;
                            bus.valid     <= 1'b1;
                            state_r       <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    // ack wins over a simultaneous start; start is only looked at in IDLE.
                    if (bus.ack) begin
                        bus.valid <= 1'b0;
                        bus.ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        bus.valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus.ready <= 1'b1;
                    bus.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl. The slice is modelled as a full
// adder, and expected results come from plain integer addition.
module tb_alu_serial_ctrl;
    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic slice_a, slice_b, slice_c, slice_s0, slice_s1;
    logic slice_out, slice_carry;

    int n_cmp = 0;
    int n_fail = 0;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .slice_a     (slice_a),
        .slice_b     (slice_b),
        .slice_c     (slice_c),
        .slice_s0    (slice_s0),
        .slice_s1    (slice_s1),
        .slice_out   (slice_out),
        .slice_carry (slice_carry)
    );

    // Slice model: a full adder that ignores s0/s1.
    assign slice_out   = slice_a ^ slice_b ^ slice_c;
    assign slice_carry = (slice_a & slice_b) | (slice_a & slice_c) | (slice_b & slice_c);

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [1:0]       op;
        logic [WIDTH-1:0] exp_res;
        logic             exp_c;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for valid. Along the way, check every slice
    // input against the operand bits and the carry chain.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic icin, input logic [1:0] iop, input bit toggle,
                          output logic [WIDTH-1:0] res, output logic rc);
        int  n;
        int  k;
        int  mask;
        int  ec;
        bit  sl_ok;
        n = 0;
        while (!bus.ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
        bus.a = ia; bus.b = ib; bus.cin = icin; bus.op = iop; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
        n = 0;
        sl_ok = 1'b1;
        while (!bus.valid && n < 200) begin
            k = n / SETTLE;
            if (k < WIDTH) begin
                mask = (1 << k) - 1;
                ec = (((int'(ia) & mask) + (int'(ib) & mask) + int'(icin)) >> k) & 1;
                if (slice_a !== ia[k] || slice_b !== ib[k] || slice_c !== ec[0] ||
                    slice_s0 !== iop[0] || slice_s1 !== iop[1])
                    sl_ok = 1'b0;
            end
            if (toggle) begin
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
                bus.op    = 2'($urandom);
                bus.cin   = 1'($urandom);
                bus.start = 1'($urandom_range(0, 1));
                bus.ack   = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        bus.ack = 1'b0;
        chk("slice_inputs_held", {31'd0, sl_ok}, 32'd1);
        chk("latency", n, WIDTH * SETTLE);
        res = bus.result;
        rc = bus.carry_out;
    endtask

    // Leave valid pending for a few clocks, then acknowledge it.
    task automatic ack_done(input int hold);
        logic [WIDTH-1:0] r;
        logic             c;
        bit               stable;
        r = bus.result;
        c = bus.carry_out;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.valid !== 1'b1 || bus.result !== r || bus.carry_out !== c) stable = 1'b0;
        end
        chk("done_hold_stable", {31'd0, stable}, 32'd1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("valid_low_after_ack", {31'd0, bus.valid}, 32'd0);
        chk("ready_high_after_ack", {31'd0, bus.ready}, 32'd1);
        chk("result_kept_after_ack", {24'd0, bus.result}, {24'd0, r});
        tick();
        chk("no_queued_op", {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        logic             rc;
        logic [WIDTH-1:0] ra, rb;
        logic             rcin;
        logic [1:0]       rop;
        int               sum;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 2'b00, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1};
        tbl[2] = '{8'h0F, 8'hF0, 1'b1, 2'b00, 8'h00, 1'b1};
        tbl[3] = '{8'hAA, 8'h55, 1'b0, 2'b01, 8'hFF, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 2'b11, 8'h00, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 2'b10, 8'hFF, 1'b1};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 2'b00, 8'h01, 1'b0};

        bus.start = 1'b0; bus.ack = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.op = 2'b00;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
        chk("rst_slice", {27'd0, slice_a, slice_b, slice_c, slice_s0, slice_s1}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op, 1'b0, res, rc);
            chk($sformatf("tbl%0d_result", i), {24'd0, res}, {24'd0, tbl[i].exp_res});
            chk($sformatf("tbl%0d_carry", i), {31'd0, rc}, {31'd0, tbl[i].exp_c});
            ack_done(i % 3);
        end

        // Op passthrough with inputs toggling every clock during RUN
        run_op(8'h5A, 8'h3C, 1'b0, 2'b10, 1'b1, res, rc);
        chk("toggle_result", {24'd0, res}, 32'h96);
        chk("toggle_carry", {31'd0, rc}, 32'd0);
        ack_done(1);

        // Handshake: hold for 5 clocks, then ack and start together
        run_op(8'h12, 8'h34, 1'b0, 2'b00, 1'b0, res, rc);
        chk("hs_result", {24'd0, res}, 32'h46);
        for (int i = 0; i < 5; i++) tick();
        chk("hs_valid_held", {31'd0, bus.valid}, 32'd1);
        chk("hs_result_held", {24'd0, bus.result}, 32'h46);
        bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
        bus.ack = 1'b1; bus.start = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("hs_valid_low", {31'd0, bus.valid}, 32'd0);
        chk("hs_ready_high", {31'd0, bus.ready}, 32'd1);
        tick();
        bus.start = 1'b0;
        chk("hs_late_start_accepted", {31'd0, bus.ready}, 32'd0);
        for (int i = 0; i < 200 && !bus.valid; i++) tick();
        chk("hs_second_result", {24'd0, bus.result}, 32'h33);
        ack_done(0);

        // Reset in the middle of an operation
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.op = 2'b01; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3 * SETTLE; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("mid_rst_result", {24'd0, bus.result}, 32'd0);
        chk("mid_rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
        chk("mid_rst_slice", {27'd0, slice_a, slice_b, slice_c, slice_s0, slice_s1}, 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 2'b00, 1'b0, res, rc);
        chk("post_rst_result", {24'd0, res}, 32'h02);
        chk("post_rst_carry", {31'd0, rc}, 32'd0);
        ack_done(0);

        // Random operations against the arithmetic reference model
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rcin = 1'($urandom);
            rop = 2'($urandom);
            sum = int'(ra) + int'(rb) + int'(rcin);
            run_op(ra, rb, rcin, rop, (i % 4) == 0, res, rc);
            chk($sformatf("rnd%0d_result", i), {24'd0, res}, sum % (1 << WIDTH));
            chk($sformatf("rnd%0d_carry", i), {31'd0, rc}, (sum >> WIDTH) & 1);
            ack_done($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer for the single-bit ALU slice (a, b, c, s0, s1 -> out, carry). Accepts two WIDTH-bit operands and a 2-bit op, then feeds the slice one bit per step, LSB first. It chains the slice carry back into c, shifts each result bit into a word register and returns the word plus final carry through a valid/ack handshake. The slice is combinational with large gate delays, so each bit is held for SETTLE clocks before it is sampled.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SETTLE, 2, clocks slice inputs are held stable before sampling (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
ready  output  1  high only in IDLE
op  input  2  operation select; op[0]->slice s0, op[1]->slice s1
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry into bit 0, sampled on accept
slice_a  output  1  current A bit to slice
slice_b  output  1  current B bit to slice
slice_c  output  1  chained carry to slice
slice_s0  output  1  registered op[0]
slice_s1  output  1  registered op[1]
slice_out  input  1  slice result bit
slice_carry  input  1  slice carry out
result  output  WIDTH  assembled result word
carry_out  output  1  carry after MSB
valid  output  1  result/carry_out valid; held until ack
ack  input  1  consumer accepts result

Behaviour:
- Every output is registered.
- States: IDLE, RUN, DONE. Reset value: state=IDLE, ready=1, valid=0, result=0, carry_out=0, all slice_* outputs=0, internal counters=0.
- IDLE: on start=1, at edge E0:
  - latch a and b into shift registers; latch op and cin
  - set carry register to cin; bit counter=0; settle counter=SETTLE-1
  - move to RUN; ready falls
- RUN:
  - slice_a and slice_b are the LSBs of the shift registers. slice_c is the carry register. slice_s1/slice_s0 are the latched op.
  - All slice_* outputs stay stable for exactly SETTLE clocks per bit.
  - Settle counter decrements each clock while nonzero.
  - Sample edge is the edge with settle counter=0. On it:
    - result shifts right with slice_out entering the MSB
    - carry register takes slice_carry
    - the A and B shift registers shift right
    - bit counter increments; settle counter reloads to SETTLE-1
  - On the sample edge of bit WIDTH-1:
    - carry_out takes slice_carry
    - state goes to DONE and valid rises
- Latency: valid first high on edge E0 + WIDTH*SETTLE (16 clocks for the defaults). Samples occur at E0+k*SETTLE, k=1..WIDTH.
- DONE:
  - valid=1; result and carry_out held.
  - When ack=1, on that edge: valid=0, ready=1, state goes to IDLE. result and carry_out keep their values until the next accept.
- ack outside DONE is ignored.
- start while ready=0 is ignored: no queueing, no effect on the operation in flight.
- start and ack high in the same DONE cycle: only ack takes effect. A new start is accepted at the earliest one clock after ready returns.
- op, a, b, cin changing during RUN or DONE have no effect.
- The carry chain is always active, whatever op is. Interpreting carry_out for non-add ops is the consumer's job.
- reset=1 in any state: the next edge restores all reset values and the in-flight operation is discarded. reset has priority over start and ack.
- Arithmetic is modulo 2^WIDTH; overflow is visible only via carry_out.

Test Plan:
Every scenario uses a bench slice model: full adder ignoring s0/s1, out=a^b^c, carry=majority(a,b,c). Defaults WIDTH=8, SETTLE=2.
- Reset check: hold reset 2 clocks -> ready=1, valid=0, result=8'h00, carry_out=0, all slice_* outputs 0.
- Add: start with a=8'h5A, b=8'h3C, cin=0, op=2'b00 -> valid rises exactly 16 clocks after the accept edge; result=8'h96, carry_out=0; each slice input pair is held 2 clocks.
- Carry wrap: a=8'hFF, b=8'h01, cin=0 -> result=8'h00, carry_out=1. Separately, a=8'h0F, b=8'hF0, cin=1 -> result=8'h00, carry_out=1.
- Op passthrough and stability: op=2'b10, then toggle op, a, b and start every clock during RUN -> slice_s1=1 and slice_s0=0 for all 8 bits; result is unaffected by the toggling; no second operation starts.
- Handshake: hold ack=0 for 5 clocks after valid -> valid and result stay stable. Then assert ack and start together -> next edge valid=0, ready=1, start not accepted. A start one clock later is accepted.
- Reset mid-operation: assert reset at bit 3 of a=8'hAA, b=8'h55 -> next edge gives full reset values. A following start with a=8'h01, b=8'h01 -> result=8'h02, carry_out=0.
